// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - request/result bundle between the core and the HI/LO multiply/divide unit
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (output start, op, op1, op2, input hi, lo, busy, done);
  modport slave  (input start, op, op1, op2, output hi, lo, busy, done);
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - sequential MIPS multiply/divide unit owning the HI and LO registers
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus one sign-fix cycle.
module mdu_hilo (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] raw_q, raw_d;
  logic [63:0] acc_q, acc_d;

  logic        op1_neg, op2_neg;
  logic [31:0] op1_mag, op2_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opa_d     = opa_q;
    raw_d     = raw_q;
    acc_d     = acc_q;

    // Only MULT and DIV (op[0]=1) treat operands as two's complement.
    op1_neg = bus.op[0] & bus.op1[31];
    op2_neg = bus.op[0] & bus.op2[31];
    op1_mag = op1_neg ? (~bus.op1 + 32'd1) : bus.op1;
    op2_mag = op2_neg ? (~bus.op2 + 32'd1) : bus.op2;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    div_trial = {acc_q[63:32], acc_q[31]};
    div_ge    = (div_trial >= {1'b0, opa_q});
    div_diff  = div_trial[31:0] - opa_q;

    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: hi_d = bus.op1;
            OP_MTLO: lo_d = bus.op1;
            OP_MULTU, OP_MULT: begin
              opa_d     = op1_mag;
              acc_d     = {32'd0, op2_mag};
              neg_res_d = op1_neg ^ op2_neg;
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = 5'd0;
              state_d   = CALC;
            end
            OP_DIVU, OP_DIV: begin
              opa_d     = op2_mag;
              acc_d     = {32'd0, op1_mag};
              neg_res_d = op1_neg ^ op2_neg;
              neg_rem_d = op1_neg;
              div0_d    = (bus.op2 == 32'd0);
              raw_d     = bus.op1;
              is_div_d  = 1'b1;
              cnt_d     = 5'd0;
              state_d   = CALC;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                         : {div_trial[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (div0_q) begin
          hi_d = raw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opa_q     <= 32'd0;
      raw_q     <= 32'd0;
      acc_q     <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      opa_q     <= opa_d;
      raw_q     <= raw_d;
      acc_q     <= acc_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo against an arithmetic reference model
module tb_mdu_hilo;
  logic clk;
  logic reset;
  int   total;
  int   passed;

  mdu_hilo_if bus ();

  mdu_hilo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the MIPS arithmetic rules.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    case (o)
      3'd0: p = {32'd0, a} * {32'd0, b};
      3'd1: p = sa * sb;
      3'd2: p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0)
          p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          p = {32'd0, 32'h8000_0000};
        else
          p = {32'(qa % qb), 32'(qa / qb)};
      end
    endcase
    eh = p[63:32];
    el = p[31:0];
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.op1   = a;
    bus.op2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.op1   = $urandom;
    bus.op2   = $urandom;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n;
    ref_model(o, a, b, eh, el);
    issue(o, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
  endtask

  initial begin
    logic [31:0] ra, rb, prev_hi;
    logic [2:0]  ro;
    int n;
    total     = 0;
    passed    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.op1   = 32'd0;
    bus.op2   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(3'b100, 32'hCAFE_0001, 32'd0);
    chk("mthi_hi", bus.hi, 32'hCAFE_0001);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(3'b101, 32'hBEEF_0002, 32'd0);
    chk("mtlo_lo", bus.lo, 32'hBEEF_0002);
    chk("mtlo_done", {31'd0, bus.done}, 32'd0);
    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    chk("nop_hi", bus.hi, 32'hCAFE_0001);
    chk("nop_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-CALC must clear outputs without a clock edge.
    issue(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'b101, 32'h1234_5678, 32'd0);
    chk("post_rst_mtlo", bus.lo, 32'h1234_5678);

    run_md("multu_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    chk("done_pulse_width", {31'd0, bus.done}, 32'd0);
    run_md("mult_neg3x7", 3'b001, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg3x7_lo_const", bus.lo, 32'hFFFF_FFEB);
    run_md("mult_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000);
    chk("mult_minmin_hi_const", bus.hi, 32'h4000_0000);
    run_md("div_neg7by2", 3'b011, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg7by2_lo_const", bus.lo, 32'hFFFF_FFFD);
    run_md("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", bus.lo, 32'h8000_0000);
    run_md("divu_zero", 3'b010, 32'hDEAD_BEEF, 32'd0);
    chk("divu_zero_hi_const", bus.hi, 32'hDEAD_BEEF);
    run_md("div_zero_neg", 3'b011, 32'hFFFF_FF00, 32'd0);
    run_md("divu_100by7", 3'b010, 32'd100, 32'd7);
    chk("divu_100by7_lo_const", bus.lo, 32'd14);

    // Issued in the done cycle, so it must be accepted immediately.
    run_md("b2b_multu", 3'b000, 32'h0001_0000, 32'h0001_0000);

    // MTHI during a busy DIV is dropped.
    issue(3'b100, 32'h1111_2222, 32'd0);
    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    issue(3'b100, 32'hAAAA_5555, 32'd0);
    chk("busy_mthi_hold", bus.hi, 32'h1111_2222);
    chk("busy_mthi_busy", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("busy_mthi_final_hi", bus.hi, 32'hFFFF_FFFF);
    chk("busy_mthi_final_lo", bus.lo, 32'hFFFF_FFFD);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      run_md($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
      prev_hi = bus.hi;
      ra = $urandom;
      issue(3'b101, ra, 32'd0);
      chk($sformatf("rand%0d_mtlo", i), bus.lo, ra);
      chk($sformatf("rand%0d_hi_kept", i), bus.hi, prev_hi);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Sequential multiply/divide unit that owns the architectural HI and LO registers of the MIPS core. The main ALU only produces single-cycle results. This block executes MULT, MULTU, DIV, DIVU, MTHI and MTLO over multiple cycles and holds the results, which MFHI/MFLO read. The core stalls on `busy`.

## Interface
- No parameters; datapath fixed at 32 bits, HI:LO at 64 bits.
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request strobe, sampled on rising edge of clk
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 no-op
- op1  in  32  rs value: multiplicand, dividend, or MTHI/MTLO data
- op2  in  32  rt value: multiplier or divisor
- hi  out  32  HI register (remainder / product upper word)
- lo  out  32  LO register (quotient / product lower word)
- busy  out  1  high while a mult/div is in flight
- done  out  1  one-cycle pulse in the cycle after HI/LO are written by a mult/div

## Operation
- States: IDLE, CALC, FIX.
- In IDLE, with start=1:
  - MTHI/MTLO: write op1 to hi (or lo) at that edge; stay in IDLE; no busy, no done.
  - Mult/div: latch operands and enter CALC.
    - Signed ops (MULT, DIV) latch operand magnitudes plus result sign flags.
    - Unsigned ops latch the raw values.
    - 5-bit iteration counter cleared to 0.
  - op 110/111: ignored.
- start while busy=1 is ignored entirely; op1, op2 and op are don't-care. The core must hold the request until busy=0.
- CALC runs 32 iterations, one per edge; the counter reaches 31 on the last.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract on a 32-bit partial remainder.
  - After iteration 31, go to FIX.
- FIX:
  - Apply sign correction. Signed multiply result is negated if the operand signs differ. Signed quotient is negated if the signs differ. Signed remainder takes the sign of the dividend.
  - Write hi and lo; return to IDLE.
- Arithmetic rules:
  - MULT/MULTU give the full 64-bit product: hi = [63:32], lo = [31:0].
  - MULT 0x80000000 × 0x80000000 gives hi=0x40000000, lo=0x00000000.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0x00000000 (wraps, no trap).
  - Divide by zero (op2=0), DIV and DIVU alike: lo=0xFFFFFFFF, hi=op1 as latched raw. Sign correction is suppressed. Latency is unchanged.
- hi/lo hold their previous values throughout CALC/FIX. No forwarding of in-flight results.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the operation. HI/LO are cleared, not partially written. After reset deasserts, the block accepts start at the first rising edge.
- Mult/div latency, with start accepted at edge E0:
  - busy=1 from just after E0 until just after E33 (33 cycles); it is derived from registered state.
  - E1–E32: the 32 CALC iterations.
  - E33: the FIX write to hi/lo.
  - done=1 for exactly the cycle after E33; busy=0 in that same cycle.
- A new start may be accepted at E34, i.e. in the done cycle. Back-to-back ops are therefore 34 cycles apart.
- MTHI/MTLO take effect at the accepting edge; the new value is visible on hi/lo the following cycle.
- done is a pulse only, never held. busy and done are never both high.

## Test plan
- Reset behaviour:
  - Stimulus: assert reset during CALC of a MULTU.
  - Required: hi=lo=0, busy=0 and done=0 immediately, without waiting for a clock edge.
  - Required: the next MTLO 0x12345678 gives lo=0x12345678 one cycle later.
- Unsigned multiply:
  - Stimulus: MULTU 0xFFFFFFFF × 0xFFFFFFFF.
  - Required: busy=1 for 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- Signed multiply:
  - Stimulus: MULT 0xFFFFFFFD (−3) × 7.
  - Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Stimulus: MULT 0x80000000 × 0x80000000.
  - Required: hi=0x40000000, lo=0.
- Signed divide:
  - Stimulus: DIV −7 / 2.
  - Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: DIV 0x80000000 / −1.
  - Required: lo=0x80000000, hi=0.
- Divide by zero and unsigned divide:
  - Stimulus: DIVU 0xDEADBEEF / 0.
  - Required: lo=0xFFFFFFFF, hi=0xDEADBEEF after 33 busy cycles.
  - Stimulus: DIVU 100 / 7.
  - Required: lo=14, hi=2.
- Busy handling and back-to-back issue:
  - Stimulus: issue MTHI 0xAAAA5555 while a DIV is busy.
  - Required: ignored; hi holds its prior value until the DIV writes it.
  - Stimulus: issue MULTU in the done cycle.
  - Required: accepted; busy rises the next cycle.
